// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, least-significant
// digit first, decimal carry rippled through a register between digit slices.
module bcd_serial_addsub #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err,
    output logic                busy,
    output logic                done
);
    localparam int              W        = 4 * DIGITS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One decimal slice; subtract uses nine's complement of db plus the preset carry.
    function automatic logic [4:0] bcd_digit_step(input logic [3:0] da, input logic [3:0] db,
                                                  input logic sub_m, input logic cin);
        logic [3:0] bx;
        logic [4:0] t;
        logic [4:0] tc;
        logic [4:0] r;
        bx = sub_m ? (4'd9 - db) : db;
        t  = {1'b0, da} + {1'b0, bx} + {4'd0, cin};
        tc = t + 5'd6;
        if (t > 5'd9) begin
            r = {1'b1, tc[3:0]};
        end else begin
            r = {1'b0, t[3:0]};
        end
        return r;
    endfunction

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            sub_q, sub_d;
    logic            carry_q, carry_d;
    logic            errac_q, errac_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [4:0]      step_s;
    logic            dig_err_s;
    logic [W-1:0]    a_shift_s;
    logic [W-1:0]    b_shift_s;
    logic [W-1:0]    res_shift_s;

    assign step_s      = bcd_digit_step(a_q[3:0], b_q[3:0], sub_q, carry_q);
    assign dig_err_s   = digit_invalid(a_q[3:0]) | digit_invalid(b_q[3:0]);
    assign a_shift_s   = W'({4'd0, a_q} >> 4);
    assign b_shift_s   = W'({4'd0, b_q} >> 4);
    assign res_shift_s = W'({step_s[3:0], res_q} >> 4);

    // Next-state and next-output logic for the start/run/done sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        errac_d = errac_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub;
                    errac_d = 1'b0;
                    idx_d   = {IDXW{1'b0}};
                    res_d   = {W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_shift_s;
                b_d     = b_shift_s;
                res_d   = res_shift_s;
                carry_d = step_s[4];
                errac_d = errac_q | dig_err_s;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (errac_d) begin
                        sum_d  = {W{1'b0}};
                        cout_d = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        sum_d  = res_shift_s;
                        cout_d = step_s[4];
                        err_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            res_q   <= {W{1'b0}};
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            errac_q <= 1'b0;
            idx_q   <= {IDXW{1'b0}};
            sum_q   <= {W{1'b0}};
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            errac_q <= errac_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: integer-arithmetic reference model checked every cycle
// on a 4-digit instance, plus literal expectations on 4-digit and 1-digit instances.
module tb_bcd_serial_addsub;
    localparam int D = 4;

    logic        clk;
    logic        reset;
    logic        start, sub;
    logic [15:0] a, b;
    logic [15:0] sum;
    logic        cout, err, busy, done;

    logic        start1, sub1;
    logic [3:0]  a1, b1;
    logic [3:0]  sum1;
    logic        cout1, err1, busy1, done1;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_serial_addsub #(.DIGITS(4), .IDXW(3)) u_dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .sum(sum), .cout(cout), .err(err), .busy(busy), .done(done)
    );

    bcd_serial_addsub #(.DIGITS(1), .IDXW(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .sum(sum1), .cout(cout1), .err(err1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: decimal value arithmetic, result packed as {err, cout, sum}.
    function automatic logic [17:0] ref_op(input logic [15:0] av, input logic [15:0] bv,
                                           input logic sv);
        int         ai, bi, r;
        logic       bad, c;
        logic [15:0] s;
        bad = 1'b0;
        ai  = 0;
        bi  = 0;
        for (int i = 3; i >= 0; i--) begin
            if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
            ai = ai * 10 + int'(av[4*i +: 4]);
            bi = bi * 10 + int'(bv[4*i +: 4]);
        end
        if (bad) return {1'b1, 1'b0, 16'h0000};
        r = sv ? (ai - bi + 10000) : (ai + bi);
        c = (r >= 10000);
        r = r % 10000;
        s = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            s[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {1'b0, c, s};
    endfunction

    int          m_left;
    logic [15:0] m_a, m_b;
    logic        m_sub;
    logic [17:0] m_res;
    logic        m_done;

    // Transaction-level model: accepts start when idle, completes D edges later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= 18'h0;
            m_a    <= 16'h0;
            m_b    <= 16'h0;
            m_sub  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_a    <= a;
                    m_b    <= b;
                    m_sub  <= sub;
                    m_left <= D;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_res  <= ref_op(m_a, m_b, m_sub);
                end
            end
        end
    end

    // Cycle-by-cycle comparison of the 4-digit instance against the model.
    always @(posedge clk) begin
        #2;
        chk("cmp_busy", 32'(busy), 32'(m_left != 0));
        chk("cmp_done", 32'(done), 32'(m_done));
        chk("cmp_sum",  32'(sum),  32'(m_res[15:0]));
        chk("cmp_cout", 32'(cout), 32'(m_res[16]));
        chk("cmp_err",  32'(err),  32'(m_res[17]));
    end

    // Issue one op from a negedge; returns at the negedge where done is seen.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input logic [15:0] es, input logic ec, input logic ee,
                         input bit poke, input string nm);
        int cyc;
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 2) begin
                start = 1'b1; a = 16'h9999; b = 16'h9999; sub = 1'b1;
            end else if (poke && cyc == 3) begin
                start = 1'b0; a = 16'h0000; b = 16'h0000;
            end
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(5));
        chk({nm, "_sum"},  32'(sum),  32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_err"},  32'(err),  32'(ee));
    endtask

    task automatic do_op1(input logic [3:0] av, input logic [3:0] bv, input logic sv,
                          input logic [3:0] es, input logic ec, input string nm);
        a1 = av; b1 = bv; sub1 = sv; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk({nm, "_busy"}, 32'(busy1), 32'(1));
        @(negedge clk);
        chk({nm, "_done"}, 32'(done1), 32'(1));
        chk({nm, "_sum"},  32'(sum1),  32'(es));
        chk({nm, "_cout"}, 32'(cout1), 32'(ec));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = 16'h0; b = 16'h0;
        start1 = 1'b0; sub1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_sum",  32'(sum),  32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, "add_basic");
        do_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "add_ovf");
        do_op(16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b0, "sub_pos");
        do_op(16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b0, 1'b0, "sub_neg");
        do_op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, "sub_zero");
        do_op(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "bad_digit");
        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "after_err");
        do_op(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1, "ignore_start");
        @(negedge clk);
        do_op(16'h8765, 16'h4321, 1'b0, 16'h3086, 1'b1, 1'b0, 1'b0, "add_idle_gap");

        // Abort after two RUN cycles.
        a = 16'h4444; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_sum",  32'(sum),  32'(0));
        chk("abort_cout", 32'(cout), 32'(0));
        chk("abort_err",  32'(err),  32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'(0));
        end
        do_op(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "post_abort");

        do_op1(4'h9, 4'h7, 1'b0, 4'h6, 1'b1, "d1_add");
        do_op1(4'h3, 4'h5, 1'b1, 4'h8, 1'b0, "d1_sub_neg");
        do_op1(4'h7, 4'h7, 1'b1, 4'h0, 1'b1, "d1_sub_eq");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
